cpu_multicycle: RTL

- Parametrised multi-cycle successor to the single-cycle ADD-only core.
- Fetches 32-bit ARM-style data-processing instructions over a req/ack instruction-memory handshake.
- Executes ADD/SUB/AND/ORR/MOV in register or immediate form, with optional NZCV flag update, through a 4-state FSM.
- Sits between the instruction memory and the FPGA top level; a retire port exposes each committed result for display and verification.

---
 rtl/cpu_multicycle.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle.sv
// rtl/cpu_multicycle.sv - multi-cycle ARM-style data-processing core
// FETCH/DECODE/EXECUTE/WRITEBACK FSM with req/ack instruction fetch and a retire port.
module cpu_multicycle #(
  parameter int          DATA_W   = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_data,
  output logic              retire_valid,
  output logic [3:0]        retire_rd,
  output logic [DATA_W-1:0] retire_data,
  output logic [3:0]        flags,
  output logic              illegal
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } state_t;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  state_t              r_state;
  state_t              w_next;
  logic                r_imem_req;
  logic [31:0]         r_pc;
  logic [31:0]         r_ir;
  logic [DATA_W-1:0]   r_regs [0:15];
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_result;
  logic                r_ill_ir;
  logic [3:0]          r_flags;
  logic                r_retire_valid;
  logic [3:0]          r_retire_rd;
  logic [DATA_W-1:0]   r_retire_data;
  logic                r_illegal;

  logic                w_accept;
  logic [3:0]          w_cmd;
  logic [3:0]          w_rn;
  logic [3:0]          w_rd;
  logic [3:0]          w_rm;
  logic                w_imm_sel;
  logic                w_set_flags;
  logic                w_legal;
  logic [31:0]         w_pc8;
  logic [DATA_W-1:0]   w_r15;
  logic [DATA_W-1:0]   w_src_a;
  logic [DATA_W-1:0]   w_src_b;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [DATA_W-1:0]   w_alu;
  logic                w_c;
  logic                w_v;
  logic [3:0]          w_nzcv;
  logic                w_unused_ir;

  assign w_accept    = (r_state == S_FETCH) && r_imem_req && imem_ack;
  assign w_cmd       = r_ir[24:21];
  assign w_rn        = r_ir[19:16];
  assign w_rd        = r_ir[15:12];
  assign w_rm        = r_ir[3:0];
  assign w_imm_sel   = r_ir[25];
  assign w_set_flags = r_ir[20];
  assign w_unused_ir = &{r_ir[31:28], r_ir[11:4]};

  assign w_legal = (r_ir[27:26] == 2'b00) &&
                   (w_cmd inside {CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR, CMD_MOV});

  // R15 reads see the pipeline-style PC+8 of the instruction being executed.
  assign w_pc8   = r_pc + 32'd8;
  assign w_r15   = w_pc8[DATA_W-1:0];
  assign w_src_a = (w_rn == 4'd15) ? w_r15 : r_regs[w_rn];
  assign w_src_b = w_imm_sel ? DATA_W'(r_ir[7:0]) :
                   ((w_rm == 4'd15) ? w_r15 : r_regs[w_rm]);

  assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
  assign w_diff = {1'b0, r_a} - {1'b0, r_b};

  always_comb begin
    w_alu = '0;
    w_c   = r_flags[1];
    w_v   = r_flags[0];
    case (w_cmd)
      CMD_ADD: begin
        w_alu = w_sum[DATA_W-1:0];
        w_c   = w_sum[DATA_W];
        w_v   = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_alu[DATA_W-1] != r_a[DATA_W-1]);
      end
      CMD_SUB: begin
        // Carry is the inverse of the borrow out of the extended subtraction.
        w_alu = w_diff[DATA_W-1:0];
        w_c   = ~w_diff[DATA_W];
        w_v   = (r_a[DATA_W-1] != r_b[DATA_W-1]) && (w_alu[DATA_W-1] != r_a[DATA_W-1]);
      end
      CMD_AND: w_alu = r_a & r_b;
      CMD_ORR: w_alu = r_a | r_b;
      CMD_MOV: w_alu = r_b;
      default: w_alu = '0;
    endcase
  end

  assign w_nzcv = {w_alu[DATA_W-1], (w_alu == '0), w_c, w_v};

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:     if (w_accept) w_next = S_DECODE;
      S_DECODE:    w_next = S_EXECUTE;
      S_EXECUTE:   w_next = S_WRITEBACK;
      S_WRITEBACK: w_next = S_FETCH;
      default:     w_next = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_FETCH;
      r_imem_req     <= 1'b0;
      r_pc           <= RESET_PC;
      r_ir           <= '0;
      r_a            <= '0;
      r_b            <= '0;
      r_result       <= '0;
      r_ill_ir       <= 1'b0;
      r_flags        <= '0;
      r_retire_valid <= 1'b0;
      r_retire_rd    <= '0;
      r_retire_data  <= '0;
      r_illegal      <= 1'b0;
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else begin
      r_state        <= w_next;
      r_imem_req     <= (w_next == S_FETCH);
      r_retire_valid <= 1'b0;
      r_illegal      <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (w_accept) r_ir <= imem_data;
        end
        S_DECODE: begin
          r_a      <= w_src_a;
          r_b      <= w_src_b;
          r_ill_ir <= ~w_legal;
        end
        S_EXECUTE: begin
          // Retire outputs are loaded here so they are visible during WRITEBACK.
          r_result <= w_alu;
          if (!r_ill_ir) begin
            r_retire_valid <= 1'b1;
            r_retire_rd    <= w_rd;
            r_retire_data  <= w_alu;
            if (w_set_flags) r_flags <= w_nzcv;
          end else begin
            r_illegal     <= 1'b1;
            r_retire_data <= '0;
          end
        end
        S_WRITEBACK: begin
          if (!r_ill_ir && (w_rd == 4'd15)) begin
            r_pc <= 32'(r_result);
          end else begin
            r_pc <= r_pc + 32'(PC_STEP);
            if (!r_ill_ir) r_regs[w_rd] <= r_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req     = r_imem_req;
  assign imem_addr    = r_pc;
  assign retire_valid = r_retire_valid;
  assign retire_rd    = r_retire_rd;
  assign retire_data  = r_retire_data;
  assign flags        = r_flags;
  assign illegal      = r_illegal;

endmodule
